// File: rtl/wf_peak_finder.sv
// -----------------------------------------------------------------------------
// wf_peak_finder
//
// Per-frame statistics on the output of the 15-tap triangular smoothing stage.
// Each accepted sample is normalised back to 10-bit scale (in_wf >> NORM_SHIFT).
// Over SAMPLES samples the block tracks the maximum and the index of its first
// occurrence, the minimum, and the number of rising threshold crossings with
// hysteresis. One result record per frame is presented on a valid/ready port.
//
// Optional feature (macro WF_PEAK_SUM_EN): adds out_sum, the 22-bit sum of all
// normalised samples of the frame. Undefined: the port and accumulator are absent.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. The source holds valid and its payload until that edge. Input
// beats presented while in_ready is low are dropped, not buffered.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   synchronous, active-high reset
//   in_valid       in   sample strobe
//   in_sof         in   first sample of a frame (qualified by in_valid)
//   in_wf          in   [IN_W]  smoothed waveform sample
//   in_ready       out  sample accepted this cycle if in_valid (low in REPORT)
//   thresh         in   [10]    crossing threshold, captured on the sof beat
//   out_valid      out  result record valid (high in REPORT)
//   out_ready      in   consumer accepts the record
//   out_peak_val   out  [10]    frame maximum
//   out_peak_idx   out  [IDX_W] index of the first occurrence of the maximum
//   out_min_val    out  [10]    frame minimum
//   out_cross_cnt  out  [8]     rising threshold crossings, saturating at 255
//   busy           out  high while accumulating a frame (ACCUM)
//   out_sum        out  [22]    sum of normalised samples (WF_PEAK_SUM_EN only)
//
// State is fully visible on the ports: IDLE = in_ready && !busy,
// ACCUM = busy, REPORT = out_valid.
// -----------------------------------------------------------------------------
module wf_peak_finder #(
  parameter int SAMPLES    = 2400,
  parameter int IN_W       = 16,
  parameter int NORM_SHIFT = 6,
  parameter int IDX_W      = 12,
  parameter int HYST       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [IN_W-1:0]  in_wf,
  output logic             in_ready,
  input  logic [9:0]       thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_peak_val,
  output logic [IDX_W-1:0] out_peak_idx,
  output logic [9:0]       out_min_val,
  output logic [7:0]       out_cross_cnt,
  output logic             busy
`ifdef WF_PEAK_SUM_EN
  ,output logic [21:0]     out_sum
`endif
);

  localparam int NW = 10;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, REPORT = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ctr_q, ctr_d;
  logic [NW-1:0]    peak_q, peak_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NW-1:0]    min_q, min_d;
  logic [NW-1:0]    thr_q, thr_d;
  logic             armed_q, armed_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [NW-1:0]    out_peak_q, out_peak_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [NW-1:0]    out_min_q, out_min_d;
  logic [7:0]       out_cnt_q, out_cnt_d;

`ifdef WF_PEAK_SUM_EN
  logic [21:0]      sum_q, sum_d;
  logic [21:0]      out_sum_q, out_sum_d;
`endif

  logic [NW-1:0] norm;
  logic          accept;
  logic          start;     // sof beat: (re)initialise the frame
  logic          step;      // ordinary in-frame beat
  logic          last;      // beat that completes the frame
  logic          unused_lsbs;

  // Low bits are fractional after removing the filter gain.
  assign norm        = NW'(in_wf >> NORM_SHIFT);
  assign unused_lsbs = ^in_wf[NORM_SHIFT-1:0];

  assign in_ready  = (state_q != REPORT);
  assign out_valid = (state_q == REPORT);
  assign busy      = (state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  // A sof in ACCUM silently aborts the running frame and restarts it.
  assign start     = accept && in_sof;
  assign step      = accept && !in_sof && (state_q == ACCUM);
  assign last      = (start && (SAMPLES == 1)) || (step && (ctr_q == LAST_IDX));

  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    peak_d     = peak_q;
    idx_d      = idx_q;
    min_d      = min_q;
    thr_d      = thr_q;
    armed_d    = armed_q;
    cnt_d      = cnt_q;
    out_peak_d = out_peak_q;
    out_idx_d  = out_idx_q;
    out_min_d  = out_min_q;
    out_cnt_d  = out_cnt_q;
`ifdef WF_PEAK_SUM_EN
    sum_d      = sum_q;
    out_sum_d  = out_sum_q;
`endif

    if (start) begin
      peak_d  = norm;
      idx_d   = '0;
      min_d   = norm;
      thr_d   = thresh;
      armed_d = (norm < thresh);
      cnt_d   = '0;
      ctr_d   = IDX_W'(1);
`ifdef WF_PEAK_SUM_EN
      sum_d   = 22'(norm);
`endif
    end else if (step) begin
      // Strict compare keeps the earliest index on ties.
      if (norm > peak_q) begin
        peak_d = norm;
        idx_d  = ctr_q;
      end
      if (norm < min_q) min_d = norm;
      // Crossing and re-arm conditions are mutually exclusive for HYST > 0.
      if (armed_q && (norm >= thr_q)) begin
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        armed_d = 1'b0;
      end else if (!armed_q && (({1'b0, norm} + 11'(HYST)) <= {1'b0, thr_q})) begin
        armed_d = 1'b1;
      end
      ctr_d = ctr_q + IDX_W'(1);
`ifdef WF_PEAK_SUM_EN
      sum_d = sum_q + 22'(norm);
`endif
    end

    // Output registers only change when a record is completed.
    if (last) begin
      out_peak_d = peak_d;
      out_idx_d  = idx_d;
      out_min_d  = min_d;
      out_cnt_d  = cnt_d;
`ifdef WF_PEAK_SUM_EN
      out_sum_d  = sum_d;
`endif
    end

    case (state_q)
      IDLE:    if (start) state_d = last ? REPORT : ACCUM;
      ACCUM:   if (last) state_d = REPORT;
      REPORT:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctr_q      <= '0;
      peak_q     <= '0;
      idx_q      <= '0;
      min_q      <= '0;
      thr_q      <= '0;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      out_peak_q <= '0;
      out_idx_q  <= '0;
      out_min_q  <= '0;
      out_cnt_q  <= '0;
`ifdef WF_PEAK_SUM_EN
      sum_q      <= '0;
      out_sum_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      peak_q     <= peak_d;
      idx_q      <= idx_d;
      min_q      <= min_d;
      thr_q      <= thr_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      out_peak_q <= out_peak_d;
      out_idx_q  <= out_idx_d;
      out_min_q  <= out_min_d;
      out_cnt_q  <= out_cnt_d;
`ifdef WF_PEAK_SUM_EN
      sum_q      <= sum_d;
      out_sum_q  <= out_sum_d;
`endif
    end
  end

  assign out_peak_val  = out_peak_q;
  assign out_peak_idx  = out_idx_q;
  assign out_min_val   = out_min_q;
  assign out_cross_cnt = out_cnt_q;
`ifdef WF_PEAK_SUM_EN
  assign out_sum       = out_sum_q;
`endif

endmodule

// File: tb/tb_wf_peak_finder.sv
// -----------------------------------------------------------------------------
// tb_wf_peak_finder
//
// Directed bench for wf_peak_finder: a table of whole-frame patterns with
// hand-computed records, plus hand-written sequences for backpressure, abort
// and mid-frame reset. Inputs change 1 time unit after the rising edge and
// outputs are sampled there too, away from the active edge.
// -----------------------------------------------------------------------------
module tb_wf_peak_finder;

  localparam int SAMPLES = 2400;
  localparam int IDX_W   = 12;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_sof;
  logic [15:0]      in_wf;
  logic             in_ready;
  logic [9:0]       thresh;
  logic             out_valid;
  logic             out_ready;
  logic [9:0]       out_peak_val;
  logic [IDX_W-1:0] out_peak_idx;
  logic [9:0]       out_min_val;
  logic [7:0]       out_cross_cnt;
  logic             busy;
`ifdef WF_PEAK_SUM_EN
  logic [21:0]      out_sum;
`endif

  int n_cmp;
  int n_err;

  wf_peak_finder dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_sof        (in_sof),
    .in_wf         (in_wf),
    .in_ready      (in_ready),
    .thresh        (thresh),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_peak_val  (out_peak_val),
    .out_peak_idx  (out_peak_idx),
    .out_min_val   (out_min_val),
    .out_cross_cnt (out_cross_cnt),
    .busy          (busy)
`ifdef WF_PEAK_SUM_EN
    ,.out_sum      (out_sum)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // ---------------- stimulus model ----------------
  // kind 0: ramp i*64 (16-bit wrap, norm = i mod 1024)
  // kind 1: constant 0x8000 (norm 512)
  // kind 2: norms alternating 99/101
  // kind 3: norms alternating 96/100
  // kind 4: sawtooth norm = (i mod 7) * 100
  function automatic logic [15:0] wf_of(input int kind, input int i);
    int n;
    case (kind)
      0:       return 16'(i * 64);
      1:       return 16'h8000;
      2:       n = (i % 2 == 0) ? 99 : 101;
      3:       n = (i % 2 == 0) ? 96 : 100;
      default: n = (i % 7) * 100;
    endcase
    return 16'(n * 64);
  endfunction

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic sof, input logic [15:0] wf);
    in_valid = 1'b1;
    in_sof   = sof;
    in_wf    = wf;
    @(posedge clk);
    #1;
  endtask

  task automatic end_beats();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_wf    = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_cycle();
    idle_cycle();
    reset = 1'b0;
  endtask

  task automatic check_record(input string tag, input int pk, input int ix,
                              input int mn, input int cn);
    check({tag, ".peak"},  int'(out_peak_val),  pk);
    check({tag, ".idx"},   int'(out_peak_idx),  ix);
    check({tag, ".min"},   int'(out_min_val),   mn);
    check({tag, ".cross"}, int'(out_cross_cnt), cn);
  endtask

  // Drive one full frame; returns how often out_valid was seen before the last beat.
  task automatic run_frame(input int kind, input int nbeats, output int early_valid);
    early_valid = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (out_valid) early_valid++;
      send_beat(i == 0, wf_of(kind, i));
    end
    end_beats();
  endtask

  task automatic handshake(input string tag);
    int spins;
    spins = 0;
    out_ready = 1'b1;
    while (!out_valid && spins < 100) begin
      idle_cycle();
      spins++;
    end
    check({tag, ".hs_timeout"}, (spins < 100) ? 1 : 0, 1);
    idle_cycle();
    out_ready = 1'b0;
    check({tag, ".valid_dropped"}, int'(out_valid), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int kind;
    int thr;
    int peak;
    int idx;
    int mn;
    int cnt;
    int sum;
  } vec_t;

  vec_t vecs[5];

  // ---------------- main sequence ----------------
  initial begin
    int early;
    int stable_bad;
    int ready_bad;
    logic [9:0] hold_peak;

    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_wf     = '0;
    thresh    = '0;
    out_ready = 1'b0;

    // Ramp: crossings at i=500 and i=1524; re-arms at 1024 and 2048, the
    // last segment only reaches 351. Sum = 2*523776 + 61776.
    vecs[0] = '{kind: 0, thr: 500, peak: 1023, idx: 1023, mn: 0,   cnt: 2,   sum: 1109328};
    // Constant 512 with threshold 512: never armed, 516 > 512 never re-arms.
    vecs[1] = '{kind: 1, thr: 512, peak: 512,  idx: 0,    mn: 512, cnt: 0,   sum: 1228800};
    // 99/101: one crossing, 99 never reaches the re-arm level 96.
    vecs[2] = '{kind: 2, thr: 100, peak: 101,  idx: 1,    mn: 99,  cnt: 1,   sum: 240000};
    // 96/100: 1200 crossings, saturating at 255.
    vecs[3] = '{kind: 3, thr: 100, peak: 100,  idx: 1,    mn: 96,  cnt: 255, sum: 235200};
    // Sawtooth: first 600 at index 6, 343 crossings -> saturated.
    vecs[4] = '{kind: 4, thr: 300, peak: 600,  idx: 6,    mn: 0,   cnt: 255, sum: 719700};

    do_reset();

    // Reset state
    check("rst.out_valid", int'(out_valid), 0);
    check("rst.busy",      int'(busy),      0);
    check("rst.in_ready",  int'(in_ready),  1);
    check_record("rst", 0, 0, 0, 0);
`ifdef WF_PEAK_SUM_EN
    check("rst.sum", int'(out_sum), 0);
`endif

    // Beats without sof in IDLE are ignored.
    send_beat(1'b0, 16'h4000);
    end_beats();
    check("idle_nosof.busy", int'(busy), 0);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      string tag;
      tag    = $sformatf("vec%0d", v);
      thresh = 10'(vecs[v].thr);
      run_frame(vecs[v].kind, SAMPLES, early);
      check({tag, ".early_valid"}, early, 0);
      check({tag, ".valid_lat1"}, int'(out_valid), 1);
      check({tag, ".in_ready"},   int'(in_ready),  0);
      check({tag, ".busy"},       int'(busy),      0);
      check_record(tag, vecs[v].peak, vecs[v].idx, vecs[v].mn, vecs[v].cnt);
`ifdef WF_PEAK_SUM_EN
      check({tag, ".sum"}, int'(out_sum), vecs[v].sum);
`endif
      handshake(tag);
      check({tag, ".hold_peak"}, int'(out_peak_val), vecs[v].peak);
    end

    // Backpressure: record stable and in_ready low for 50 cycles while beats arrive.
    thresh = 10'd512;
    run_frame(1, SAMPLES, early);
    check("bp.valid", int'(out_valid), 1);
    hold_peak  = out_peak_val;
    stable_bad = 0;
    ready_bad  = 0;
    for (int c = 0; c < 50; c++) begin
      if (in_ready !== 1'b0) ready_bad++;
      if (out_valid !== 1'b1 || out_peak_val !== 10'd512 || out_min_val !== 10'd512 ||
          out_peak_idx !== '0 || out_cross_cnt !== 8'd0) stable_bad++;
      send_beat(c == 0, 16'(7 * 64));
    end
    check("bp.in_ready_low", ready_bad, 0);
    check("bp.record_stable", stable_bad, 0);
    check("bp.hold_peak", int'(hold_peak), 512);
    // Handshake edge with a sof pending: that beat is dropped, the next is taken.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sof    = 1'b1;
    in_wf     = 16'(7 * 64);
    idle_cycle();
    out_ready = 1'b0;
    check("bp.after_hs_valid", int'(out_valid), 0);
    check("bp.after_hs_busy",  int'(busy),      0);
    check("bp.after_hs_ready", int'(in_ready),  1);
    idle_cycle();
    end_beats();
    check("bp.sof_accepted", int'(busy), 1);
    do_reset();

    // Abort: 1000 samples of norm 900, then sof norm 7 and 2399 samples of norm 5.
    thresh = 10'd6;
    early  = 0;
    for (int i = 0; i < 1000; i++) begin
      if (out_valid) early++;
      send_beat(i == 0, 16'(900 * 64));
    end
    for (int i = 0; i < SAMPLES; i++) begin
      if (out_valid) early++;
      send_beat(1'b1 && (i == 0), (i == 0) ? 16'(7 * 64) : 16'(5 * 64));
    end
    end_beats();
    check("abort.no_early_record", early, 0);
    check("abort.valid", int'(out_valid), 1);
    check_record("abort", 7, 0, 5, 0);
`ifdef WF_PEAK_SUM_EN
    check("abort.sum", int'(out_sum), 7 + 2399 * 5);
`endif
    handshake("abort");
    idle_cycle();
    check("abort.single_record", int'(out_valid), 0);

    // Reset at sample 1200 of a ramp frame: everything cleared, no record.
    thresh = 10'd500;
    run_frame(0, 1200, early);
    check("midrst.busy_before", int'(busy), 1);
    reset = 1'b1;
    idle_cycle();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) idle_cycle();
    check("midrst.out_valid", int'(out_valid), 0);
    check("midrst.busy",      int'(busy),      0);
    check("midrst.in_ready",  int'(in_ready),  1);
    check_record("midrst", 0, 0, 0, 0);
`ifdef WF_PEAK_SUM_EN
    check("midrst.sum", int'(out_sum), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
